present80_decrypt_core: RTL and testbench

- Round-based PRESENT-80 decryption engine.
- Counterpart to the team's round-based PRESENT-80 encryption datapath; built in the same area-optimised style: one 64-bit state register, one 80-bit key register and one round counter.
- On each run it first replays the forward key schedule to reach round key K32, then peels off rounds 31..1 using the inverse S-box, inverse pLayer and inverse key update.
- A cached K32 lets consecutive blocks under the same key skip key preparation.

---
 rtl/present80_decrypt_core.sv | 185 ++++++++++++++++++
 tb/tb_present80_decrypt_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/present80_decrypt_core.sv
// Round-based PRESENT-80 decryption: replays the forward key schedule up to K32,
// then unwinds rounds 31..1; a cached K32 lets same-key blocks skip key preparation.
module present80_decrypt_core #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_reuse,
    input  logic [63:0] ciphertext,
    input  logic [79:0] key,
    output logic        busy,
    output logic        done,
    output logic [63:0] plaintext
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEYPREP = 2'd1,
        DECRYPT = 2'd2
    } fsm_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    fsm_t        fsm;
    logic [63:0] state_q;
    logic [79:0] key_q;
    logic [79:0] cache_q;
    logic        cache_valid;
    logic [4:0]  cnt_q;

    logic [79:0] key_fwd;
    logic [79:0] key_inv;
    logic [63:0] round_out;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ i;
        return r;
    endfunction

    // Exact inverse of fwd_update: undo the counter XOR, the S-box, then the rotation.
    function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ i;
        r[79:76]   = sbox_inv(r[79:76]);
        r          = {r[60:0], r[79:61]};
        return r;
    endfunction

    function automatic logic [63:0] inv_player(input logic [63:0] s);
        logic [63:0] o;
        for (int j = 0; j < 63; j++) begin
            o[j] = s[(16 * j) % 63];
        end
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = sbox_inv(s[4*n +: 4]);
        end
        return o;
    endfunction

    always_comb begin
        key_fwd   = fwd_update(key_q, cnt_q);
        key_inv   = inv_update(key_q, cnt_q);
        round_out = inv_sbox_layer(inv_player(state_q)) ^ key_inv[79:16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            plaintext   <= '0;
            cnt_q       <= '0;
            cache_valid <= 1'b0;
            state_q     <= '0;
            key_q       <= '0;
            cache_q     <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (key_reuse && cache_valid) begin
                            key_q   <= cache_q;
                            state_q <= ciphertext ^ cache_q[79:16];
                            cnt_q   <= LAST_ROUND;
                            fsm     <= DECRYPT;
                        end else begin
                            // state_q parks the ciphertext while K32 is being derived.
                            key_q   <= key;
                            state_q <= ciphertext;
                            cnt_q   <= 5'd1;
                            fsm     <= KEYPREP;
                        end
                    end
                end
                KEYPREP: begin
                    key_q <= key_fwd;
                    if (cnt_q == LAST_ROUND) begin
                        cache_q     <= key_fwd;
                        cache_valid <= 1'b1;
                        state_q     <= state_q ^ key_fwd[79:16];
                        fsm         <= DECRYPT;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DECRYPT: begin
                    key_q   <= key_inv;
                    state_q <= round_out;
                    if (cnt_q == 5'd1) begin
                        plaintext <= round_out;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present80_decrypt_core.sv
// Known-answer and control-path bench for present80_decrypt_core: plaintext and latency
// expectations are queued at start and retired when done pulses.
module tb_present80_decrypt_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic        key_reuse;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] plaintext;

    logic [63:0] exp_q[$];
    int          lat_q[$];
    int          total;
    int          bad;
    int          cyc;
    int          start_cyc;
    int          done_cnt;

    localparam logic [79:0] K_ZERO = 80'h0;
    localparam logic [79:0] K_ONES = {80{1'b1}};
    localparam logic [63:0] P_ZERO = 64'h0;
    localparam logic [63:0] P_ONES = {64{1'b1}};

    present80_decrypt_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_reuse  (key_reuse),
        .ciphertext (ciphertext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // scoreboard: retire one queued expectation per done pulse
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 64'(1), 64'(0));
            end else begin
                check_val("plaintext", plaintext, exp_q.pop_front());
                check_val("latency", 64'(cyc - start_cyc), 64'(lat_q.pop_front()));
            end
        end
    end

    // driver: one block; spam>0 pulses start with random data while busy
    task automatic do_run(input logic [79:0] k, input logic [63:0] ct, input logic reuse,
                          input logic [63:0] exp_pt, input int exp_lat, input bit spam);
        int n;
        int busy_cnt;
        @(negedge clk);
        start      = 1'b1;
        key        = k;
        ciphertext = ct;
        key_reuse  = reuse;
        start_cyc  = cyc + 1;
        exp_q.push_back(exp_pt);
        lat_q.push_back(exp_lat);
        @(negedge clk);
        start    = 1'b0;
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 200) begin
            if (busy) busy_cnt++;
            if (spam && $urandom_range(0, 3) == 0) begin
                start      = 1'b1;
                key_reuse  = 1'($urandom_range(0, 1));
                ciphertext = {$urandom, $urandom};
                key        = {16'($urandom), $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check_val("done_seen", 64'(done), 64'(1));
        check_val("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        check_val("busy_at_done", 64'(busy), 64'(0));
        @(negedge clk);
        check_val("done_pulse_width", 64'(done), 64'(0));
    endtask

    initial begin
        int dc;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        start_cyc  = 0;
        done_cnt   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        key_reuse  = 1'b0;
        ciphertext = '0;
        key        = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_plaintext", plaintext, 64'h0);

        // known-answer vectors
        do_run(K_ZERO, 64'h5579C1387B228445, 1'b0, P_ZERO, 62, 1'b0);
        do_run(K_ONES, 64'hE72C46C0F5945049, 1'b0, P_ZERO, 62, 1'b0);
        do_run(K_ZERO, 64'hA112FFC72F68417B, 1'b0, P_ONES, 62, 1'b0);
        do_run(K_ONES, 64'h3333DCD3213210D2, 1'b0, P_ONES, 62, 1'b0);

        // cached K32 from the all-ones key; supplied key is ignored
        do_run(K_ZERO, 64'hE72C46C0F5945049, 1'b1, P_ZERO, 31, 1'b0);
        do_run(K_ZERO, 64'h3333DCD3213210D2, 1'b1, P_ONES, 31, 1'b0);

        // reuse requested with an empty cache falls back to a full run
        apply_reset();
        do_run(K_ZERO, 64'h5579C1387B228445, 1'b1, P_ZERO, 62, 1'b0);

        // start pulses while busy are ignored
        dc = done_cnt;
        do_run(K_ONES, 64'h3333DCD3213210D2, 1'b0, P_ONES, 62, 1'b1);
        repeat (70) @(negedge clk);
        check_val("single_done", 64'(done_cnt - dc), 64'(1));
        check_val("plaintext_held", plaintext, P_ONES);

        // reset in the middle of a full run
        @(negedge clk);
        start      = 1'b1;
        key_reuse  = 1'b0;
        key        = K_ZERO;
        ciphertext = 64'h5579C1387B228445;
        @(negedge clk);
        start = 1'b0;
        repeat (38) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", 64'(busy), 64'(0));
        check_val("abort_done", 64'(done), 64'(0));
        check_val("abort_plaintext", plaintext, 64'h0);
        dc = done_cnt;
        repeat (80) @(negedge clk);
        check_val("abort_no_done", 64'(done_cnt - dc), 64'(0));

        // cache was cleared by reset, so this reuse request pays for key preparation
        do_run(K_ZERO, 64'h5579C1387B228445, 1'b1, P_ZERO, 62, 1'b0);

        repeat (3) @(negedge clk);
        check_val("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
